// File: rtl/sort_stream_stats_if.sv
// sort_stream_stats_if
//   Bundles the sorted-byte input stream and the per-frame statistics outputs
//   of sort_stream_stats.
//   master: drives in_valid/in_data and observes the results. This is the
//           sort core side, or a testbench.
//   slave : sort_stream_stats itself.
//   Signals: in_valid, in_data[DW], stat_valid, stat_min/max/median[DW],
//            stat_sum[SW], order_err, frame_cnt[16], abort.
interface sort_stream_stats_if #(
  parameter int DW = 8,
  parameter int SW = 12
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          stat_valid;
  logic [DW-1:0] stat_min;
  logic [DW-1:0] stat_max;
  logic [DW-1:0] stat_median;
  logic [SW-1:0] stat_sum;
  logic          order_err;
  logic [15:0]   frame_cnt;
  logic          abort;

  modport master (
    output in_valid, in_data,
    input  stat_valid, stat_min, stat_max, stat_median, stat_sum,
           order_err, frame_cnt, abort
  );

  modport slave (
    input  in_valid, in_data,
    output stat_valid, stat_min, stat_max, stat_median, stat_sum,
           order_err, frame_cnt, abort
  );
endinterface

// File: rtl/sort_stream_stats.sv
// sort_stream_stats
//   Consumes the sorted output bursts of the bubble-sort core. A frame is N
//   bytes long. For each frame the block checks that the bytes never
//   decrease, and it reports the min, max, median (the byte at index N/2)
//   and the sum of the frame. Results are registered and are announced by a
//   one-cycle stat_valid pulse on the cycle after the N-th byte is sampled.
//   The results hold until the next report. frame_cnt counts the completed
//   frames.
//
//   Ports:
//     clk - rising-edge clock.
//     rst - asynchronous, active-high reset.
//     bus - sort_stream_stats_if.slave. It carries the in_valid/in_data
//           input stream and the stat_*, order_err, frame_cnt and abort
//           outputs.
//
//   Optional macro BURST_TIMEOUT_EN:
//     When defined, a partial frame is discarded after TIMEOUT consecutive
//     idle cycles, and abort pulses for one cycle. When undefined, abort is
//     tied to 0 and gaps inside a frame may be any length.
module sort_stream_stats #(
  parameter int N       = 16,
  parameter int DW      = 8,
  parameter int SW      = DW + $clog2(N),
  parameter int TIMEOUT = 32
) (
  input logic               clk,
  input logic               rst,
  sort_stream_stats_if.slave bus
);

  if (N < 2 || N > 256 || TIMEOUT < 1) begin : g_param_check
    $error("sort_stream_stats: N must be 2..256 and TIMEOUT must be >= 1");
  end

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] HALF_IDX = CW'(N / 2);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    REPORT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] prev_q, prev_d;
  logic [DW-1:0] min_acc_q, min_acc_d;
  logic [DW-1:0] med_acc_q, med_acc_d;
  logic [SW-1:0] sum_acc_q, sum_acc_d;
  logic          err_acc_q, err_acc_d;

  logic          stat_valid_q, stat_valid_d;
  logic [DW-1:0] stat_min_q, stat_min_d;
  logic [DW-1:0] stat_max_q, stat_max_d;
  logic [DW-1:0] stat_median_q, stat_median_d;
  logic [SW-1:0] stat_sum_q, stat_sum_d;
  logic          order_err_q, order_err_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

`ifdef BURST_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);
  logic [GW-1:0] gap_q, gap_d;
  logic          abort_q, abort_d;
`endif

  logic [SW-1:0] in_ext;
  logic [SW-1:0] sum_next;
  logic          err_next;
  logic [DW-1:0] med_next;

  always_comb begin
    in_ext   = SW'(bus.in_data);
    sum_next = sum_acc_q + in_ext;
    err_next = err_acc_q | (bus.in_data < prev_q);
    med_next = (count_q == HALF_IDX) ? bus.in_data : med_acc_q;

    state_d       = state_q;
    count_d       = count_q;
    prev_d        = prev_q;
    min_acc_d     = min_acc_q;
    med_acc_d     = med_acc_q;
    sum_acc_d     = sum_acc_q;
    err_acc_d     = err_acc_q;
    stat_valid_d  = 1'b0;
    stat_min_d    = stat_min_q;
    stat_max_d    = stat_max_q;
    stat_median_d = stat_median_q;
    stat_sum_d    = stat_sum_q;
    order_err_d   = order_err_q;
    frame_cnt_d   = frame_cnt_q;
`ifdef BURST_TIMEOUT_EN
    gap_d   = '0;
    abort_d = 1'b0;
`endif

    unique case (state_q)
      // A byte arriving in REPORT starts the next frame, exactly as in IDLE.
      // This keeps back-to-back frames at full throughput.
      IDLE, REPORT: begin
        if (bus.in_valid) begin
          min_acc_d = bus.in_data;
          prev_d    = bus.in_data;
          sum_acc_d = in_ext;
          err_acc_d = 1'b0;
          count_d   = CW'(1);
          if (HALF_IDX == '0) med_acc_d = bus.in_data;
          state_d = COLLECT;
        end else begin
          state_d = IDLE;
        end
      end

      COLLECT: begin
        if (bus.in_valid) begin
          sum_acc_d = sum_next;
          err_acc_d = err_next;
          med_acc_d = med_next;
          prev_d    = bus.in_data;
          count_d   = count_q + CW'(1);
          // The N-th byte loads the result registers directly. The next-state
          // values are used, so the outputs are valid in the REPORT cycle.
          if (count_q == LAST_IDX) begin
            stat_valid_d  = 1'b1;
            stat_min_d    = min_acc_q;
            stat_max_d    = bus.in_data;
            stat_median_d = med_next;
            stat_sum_d    = sum_next;
            order_err_d   = err_next;
            frame_cnt_d   = frame_cnt_q + 16'd1;
            state_d       = REPORT;
          end
        end
`ifdef BURST_TIMEOUT_EN
        else if (gap_q == GAP_LAST) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      prev_q        <= '0;
      min_acc_q     <= '0;
      med_acc_q     <= '0;
      sum_acc_q     <= '0;
      err_acc_q     <= 1'b0;
      stat_valid_q  <= 1'b0;
      stat_min_q    <= '0;
      stat_max_q    <= '0;
      stat_median_q <= '0;
      stat_sum_q    <= '0;
      order_err_q   <= 1'b0;
      frame_cnt_q   <= '0;
`ifdef BURST_TIMEOUT_EN
      gap_q         <= '0;
      abort_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      prev_q        <= prev_d;
      min_acc_q     <= min_acc_d;
      med_acc_q     <= med_acc_d;
      sum_acc_q     <= sum_acc_d;
      err_acc_q     <= err_acc_d;
      stat_valid_q  <= stat_valid_d;
      stat_min_q    <= stat_min_d;
      stat_max_q    <= stat_max_d;
      stat_median_q <= stat_median_d;
      stat_sum_q    <= stat_sum_d;
      order_err_q   <= order_err_d;
      frame_cnt_q   <= frame_cnt_d;
`ifdef BURST_TIMEOUT_EN
      gap_q         <= gap_d;
      abort_q       <= abort_d;
`endif
    end
  end

  assign bus.stat_valid  = stat_valid_q;
  assign bus.stat_min    = stat_min_q;
  assign bus.stat_max    = stat_max_q;
  assign bus.stat_median = stat_median_q;
  assign bus.stat_sum    = stat_sum_q;
  assign bus.order_err   = order_err_q;
  assign bus.frame_cnt   = frame_cnt_q;
`ifdef BURST_TIMEOUT_EN
  assign bus.abort       = abort_q;
`else
  assign bus.abort       = 1'b0;
`endif

endmodule
